// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder_if
//  Purpose  : CPU data-memory bus between the CPU (master) and the memory /
//             MMIO responder (slave).
//  Signals  : address_i   [31:0]  byte address from CPU
//             data_i      [31:0]  write data from CPU
//             wren_i              write strobe
//             rden_i              read strobe (qualifies side-effect reads)
//             byte_mode_i         1 = byte access, 0 = word access
//             data_o      [31:0]  registered read data back to CPU
//             err_o               one-cycle pulse on an unmapped access
//  Revision : 1.0  initial release
// ============================================================================
interface data_mem_responder_if;
   logic [31:0] address_i;
   logic [31:0] data_i;
   logic        wren_i;
   logic        rden_i;
   logic        byte_mode_i;
   logic [31:0] data_o;
   logic        err_o;

   modport master (
      output address_i, data_i, wren_i, rden_i, byte_mode_i,
      input  data_o, err_o
   );

   modport slave (
      input  address_i, data_i, wren_i, rden_i, byte_mode_i,
      output data_o, err_o
   );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : Responder end of the CPU data-memory interface. Word-organised
//             synchronous RAM with byte-lane writes plus a small MMIO window
//             (LED register, synchronised button with sticky press flag,
//             RAM write counter).
//  Ports    : CLK        clock, rising edge
//             RST        synchronous reset, active-high
//             bus        data_mem_responder_if.slave (address/data/strobes in,
//                        registered read data and error pulse out)
//             button_i   asynchronous board button
//             LEDs_o     LED register
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_responder #(
   parameter int          ADDR_W    = 12,
   parameter int          DATA_W    = 32,
   parameter logic [31:0] MMIO_BASE = 32'h0004_0000
) (
   input  wire logic               CLK,
   input  wire logic               RST,
   data_mem_responder_if.slave     bus,
   input  wire logic               button_i,
   output logic [7:0]              LEDs_o
);

   localparam int c_depth = 2 ** ADDR_W;

   // ------------------------------------------------------------------------
   // Storage and registers
   // ------------------------------------------------------------------------
   logic [DATA_W-1:0] r_mem [0:c_depth-1];

   logic [31:0] r_data;
   logic        r_err;
   logic [7:0]  r_leds;
   logic [1:0]  r_sync;       // r_sync[1] is the synchronised button
   logic        r_btn_prev;
   logic        r_sticky;
   logic [31:0] r_wcnt;

   // ------------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------------
   logic              w_is_ram;
   logic              w_is_led;
   logic              w_is_btn;
   logic              w_is_wcnt;
   logic              w_unmapped;
   logic [ADDR_W-1:0] w_idx;
   logic [1:0]        w_lane;
   logic              w_ram_we;
   logic              w_btn_s;
   logic              w_btn_rise;
   logic [DATA_W-1:0] w_ram_word;
   logic [7:0]        w_ram_byte;
   logic [31:0]       w_rd_data;

   // RAM occupies byte addresses 0 .. 4*depth-1: all bits above the
   // word index and lane must be zero.
   assign w_is_ram   = ((bus.address_i >> (ADDR_W + 2)) == 32'd0);
   assign w_is_led   = (bus.address_i == MMIO_BASE);
   assign w_is_btn   = (bus.address_i == MMIO_BASE + 32'd4);
   assign w_is_wcnt  = (bus.address_i == MMIO_BASE + 32'd8);
   assign w_unmapped = !(w_is_ram || w_is_led || w_is_btn || w_is_wcnt);

   assign w_idx  = bus.address_i[ADDR_W+1:2];
   assign w_lane = bus.address_i[1:0];

   // Reset blocks the RAM write in the same cycle.
   assign w_ram_we = !RST && bus.wren_i && w_is_ram;

   assign w_btn_s    = r_sync[1];
   assign w_btn_rise = w_btn_s && !r_btn_prev;

   // Asynchronous array read feeding the registered output gives read-first
   // behaviour: the write below lands only after this edge.
   assign w_ram_word = r_mem[w_idx];
   assign w_ram_byte = w_ram_word[{w_lane, 3'b000} +: 8];

   always_comb begin
      w_rd_data = 32'd0;
      if (w_is_ram) begin
         w_rd_data = bus.byte_mode_i ? {24'd0, w_ram_byte} : w_ram_word;
      end else if (w_is_led) begin
         w_rd_data = {24'd0, r_leds};
      end else if (w_is_btn) begin
         w_rd_data = {30'd0, r_sticky, w_btn_s};
      end else if (w_is_wcnt) begin
         w_rd_data = r_wcnt;
      end
   end

   // ------------------------------------------------------------------------
   // RAM with byte-lane writes (contents are not reset)
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (w_ram_we) begin
         if (bus.byte_mode_i) begin
            r_mem[w_idx][{w_lane, 3'b000} +: 8] <= bus.data_i[7:0];
         end else begin
            r_mem[w_idx] <= bus.data_i;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Read data, error pulse and MMIO registers
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_data     <= 32'd0;
         r_err      <= 1'b0;
         r_leds     <= 8'd0;
         r_sync     <= 2'b00;
         r_btn_prev <= 1'b0;
         r_sticky   <= 1'b0;
         r_wcnt     <= 32'd0;
      end else begin
         r_data     <= w_rd_data;
         r_err      <= w_unmapped && (bus.wren_i || bus.rden_i);
         r_sync     <= {r_sync[0], button_i};
         r_btn_prev <= w_btn_s;

         if (bus.wren_i && w_is_led) begin
            r_leds <= bus.data_i[7:0];
         end

         // A new press takes priority over a clearing read in the same cycle.
         if (w_btn_rise) begin
            r_sticky <= 1'b1;
         end else if (bus.rden_i && w_is_btn) begin
            r_sticky <= 1'b0;
         end

         if (bus.wren_i && w_is_wcnt) begin
            r_wcnt <= 32'd0;
         end else if (bus.wren_i && w_is_ram) begin
            r_wcnt <= r_wcnt + 32'd1;
         end
      end
   end

   assign bus.data_o = r_data;
   assign bus.err_o  = r_err;
   assign LEDs_o     = r_leds;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Purpose  : Self-checking bench for data_mem_responder. Each driven cycle
//             pushes its expected read data / error onto a queue; the entry
//             is popped and compared once the DUT has registered its output.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

   localparam logic [31:0] c_mmio = 32'h0004_0000;
   localparam logic [31:0] c_led  = c_mmio;
   localparam logic [31:0] c_btn  = c_mmio + 32'd4;
   localparam logic [31:0] c_wcnt = c_mmio + 32'd8;

   logic       CLK = 1'b0;
   logic       RST;
   logic       button_i;
   logic [7:0] LEDs_o;

   data_mem_responder_if bus ();

   data_mem_responder #(
      .ADDR_W    (12),
      .DATA_W    (32),
      .MMIO_BASE (c_mmio)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .bus      (bus),
      .button_i (button_i),
      .LEDs_o   (LEDs_o)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string       tag;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // One bus cycle: drive on the falling edge, compare just after the rise.
   task automatic drive(input logic rst_v, input logic [31:0] addr,
                        input logic [31:0] wd, input logic we, input logic re,
                        input logic bm, input logic chk,
                        input logic [31:0] exp_d, input logic exp_e,
                        input string tag);
      exp_t e;
      @(negedge CLK);
      RST             = rst_v;
      bus.address_i   = addr;
      bus.data_i      = wd;
      bus.wren_i      = we;
      bus.rden_i      = re;
      bus.byte_mode_i = bm;
      if (chk) exp_q.push_back('{tag, exp_d, exp_e});
      @(posedge CLK);
      #1;
      if (chk) begin
         e = exp_q.pop_front();
         check_eq(e.tag, bus.data_o, e.data);
         check_eq({e.tag, "/err"}, {31'd0, bus.err_o}, {31'd0, e.err});
      end
   endtask

   task automatic rd(input logic [31:0] addr, input logic bm, input logic re,
                     input logic [31:0] exp_d, input logic exp_e,
                     input string tag);
      drive(1'b0, addr, 32'd0, 1'b0, re, bm, 1'b1, exp_d, exp_e, tag);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] wd,
                     input logic bm, input logic chk, input logic [31:0] exp_d,
                     input string tag);
      drive(1'b0, addr, wd, 1'b1, 1'b0, bm, chk, exp_d, 1'b0, tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      RST             = 1'b1;
      button_i        = 1'b0;
      bus.address_i   = 32'd0;
      bus.data_i      = 32'd0;
      bus.wren_i      = 1'b0;
      bus.rden_i      = 1'b0;
      bus.byte_mode_i = 1'b0;

      // Reset state
      drive(1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, "reset0");
      drive(1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, "reset1");
      check_eq("reset_leds", {24'd0, LEDs_o}, 32'd0);
      rd(c_led,  1'b0, 1'b1, 32'd0, 1'b0, "rd_led_rst");
      rd(c_btn,  1'b0, 1'b1, 32'd0, 1'b0, "rd_btn_rst");
      rd(c_wcnt, 1'b0, 1'b1, 32'd0, 1'b0, "rd_wcnt_rst");

      // Word write / read
      wr(32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, "wr_10");
      rd(32'h10, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, "rd_10_word");
      rd(c_wcnt, 1'b0, 1'b1, 32'd1, 1'b0, "wcnt_1");

      // Byte write lane 2; the write cycle itself returns the old lane 2 byte
      wr(32'h12, 32'h0000_00AA, 1'b1, 1'b1, 32'h0000_00AD, "wrb_12_old");
      rd(32'h10, 1'b0, 1'b1, 32'hDEAA_BEEF, 1'b0, "rd_10_merged");
      rd(32'h12, 1'b1, 1'b1, 32'h0000_00AA, 1'b0, "rdb_12");

      // Read-during-write returns the old word
      wr(32'h10, 32'h1234_5678, 1'b0, 1'b1, 32'hDEAA_BEEF, "rdw_10");
      rd(32'h10, 1'b0, 1'b1, 32'h1234_5678, 1'b0, "rd_10_new");
      rd(c_wcnt, 1'b0, 1'b1, 32'd3, 1'b0, "wcnt_3");

      // LED register
      wr(c_led, 32'h0000_005A, 1'b0, 1'b1, 32'd0, "wr_led_5a");
      check_eq("leds_5a", {24'd0, LEDs_o}, 32'h5A);
      wr(c_led, 32'h0000_01FF, 1'b0, 1'b1, 32'h5A, "wr_led_1ff");
      check_eq("leds_ff", {24'd0, LEDs_o}, 32'hFF);
      rd(c_led, 1'b1, 1'b1, 32'hFF, 1'b0, "rdb_led_as_word");

      // RAM boundaries
      wr(32'h0000_0000, 32'hCAFE_F00D, 1'b0, 1'b0, 32'd0, "wr_0");
      wr(32'h0000_3FFC, 32'h0BAD_F00D, 1'b0, 1'b0, 32'd0, "wr_top");
      rd(32'h0000_3FFC, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, "rd_top");
      rd(32'h0000_0000, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, "rd_0");
      rd(c_wcnt, 1'b0, 1'b1, 32'd5, 1'b0, "wcnt_5");

      // Unmapped accesses
      drive(1'b0, 32'hFFFF_0000, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 1'b1,
            32'd0, 1'b1, "unm_wr");
      rd(c_wcnt, 1'b0, 1'b1, 32'd5, 1'b0, "wcnt_after_unm");
      rd(32'h0000_0000, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, "rd_0_after_unm");
      rd(32'h0000_4000, 1'b0, 1'b1, 32'd0, 1'b1, "unm_rd_ram_end");
      rd(c_mmio + 32'd12, 1'b0, 1'b1, 32'd0, 1'b1, "unm_rd_mmio_end");
      rd(32'h0000_4000, 1'b0, 1'b0, 32'd0, 1'b0, "unm_no_strobe");

      // WCNT clear by write
      wr(c_wcnt, 32'h0000_1234, 1'b0, 1'b1, 32'd5, "wr_wcnt_clr");
      rd(c_wcnt, 1'b0, 1'b1, 32'd0, 1'b0, "wcnt_cleared");

      // Button: high for two cycles, then released
      button_i = 1'b1;
      rd(c_btn, 1'b0, 1'b0, 32'd0, 1'b0, "btn_a");
      rd(c_btn, 1'b0, 1'b0, 32'd0, 1'b0, "btn_b");
      button_i = 1'b0;
      rd(c_btn, 1'b0, 1'b0, 32'd1, 1'b0, "btn_c");
      rd(c_btn, 1'b0, 1'b0, 32'd3, 1'b0, "btn_d");
      rd(c_btn, 1'b0, 1'b0, 32'd2, 1'b0, "btn_released");
      rd(c_btn, 1'b0, 1'b1, 32'd2, 1'b0, "btn_clear_rd");
      rd(c_btn, 1'b0, 1'b0, 32'd0, 1'b0, "btn_cleared");

      // Press and clearing read in the same cycle: the press wins
      button_i = 1'b1;
      rd(c_btn, 1'b0, 1'b0, 32'd0, 1'b0, "btn_h");
      rd(c_btn, 1'b0, 1'b0, 32'd0, 1'b0, "btn_i");
      rd(c_btn, 1'b0, 1'b1, 32'd1, 1'b0, "btn_rise_and_clear");
      rd(c_btn, 1'b0, 1'b1, 32'd3, 1'b0, "btn_set_wins");
      button_i = 1'b0;
      rd(c_btn, 1'b0, 1'b0, 32'd1, 1'b0, "btn_l");
      rd(c_btn, 1'b0, 1'b0, 32'd1, 1'b0, "btn_m");
      rd(c_btn, 1'b0, 1'b0, 32'd0, 1'b0, "btn_n");

      // WCNT wrap
      force dut.r_wcnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_wcnt;
      rd(c_wcnt, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, "wcnt_preload");
      wr(32'h20, 32'h0000_0001, 1'b0, 1'b0, 32'd0, "wr_20");
      rd(c_wcnt, 1'b0, 1'b1, 32'd0, 1'b0, "wcnt_wrap");

      // Reset together with a write
      wr(32'h24, 32'h0000_0002, 1'b0, 1'b0, 32'd0, "wr_24");
      rd(c_wcnt, 1'b0, 1'b1, 32'd1, 1'b0, "wcnt_pre_rst");
      drive(1'b1, 32'h10, 32'hBADB_AD00, 1'b1, 1'b0, 1'b0, 1'b1,
            32'd0, 1'b0, "rst_with_wr");
      check_eq("leds_after_rst", {24'd0, LEDs_o}, 32'd0);
      rd(32'h10, 1'b0, 1'b1, 32'h1234_5678, 1'b0, "rd_10_after_rst");
      rd(c_wcnt, 1'b0, 1'b1, 32'd0, 1'b0, "wcnt_after_rst");
      rd(c_led,  1'b0, 1'b1, 32'd0, 1'b0, "led_after_rst");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the CPU data-memory interface; drives data_mem_out_data_i back to CPU.
- Consumes the address, write data and write enable that CPU drives.
- Contains a word-organised synchronous RAM with byte-lane writes, plus a small MMIO window: LED register, debounced-free synchronised button with sticky press flag, and a RAM write counter.
- Sits between CPU and the board I/O; the CPU_tb write monitor remains valid unchanged.

Parameters:
- ADDR_W, 12, word-index bits of the RAM (depth 2**ADDR_W words).
- DATA_W, 32, data width; fixed at 32, byte lanes = 4.
- MMIO_BASE, 32'h0004_0000, byte address of the first MMIO register.

Ports:
- CLK  input  1  clock, all logic on rising edge.
- RST  input  1  synchronous reset, active-high.
- address_i  input  32  byte address from CPU.
- data_i  input  32  write data from CPU.
- wren_i  input  1  write strobe, one write per cycle high.
- rden_i  input  1  read strobe; qualifies side-effect reads.
- byte_mode_i  input  1  1 = byte access on lane address_i[1:0]; 0 = word access.
- button_i  input  1  asynchronous board button.
- data_o  output  32  registered read data.
- LEDs_o  output  8  LED register.
- err_o  output  1  one-cycle pulse on an access to an unmapped address.

Behaviour:
- Reset values: data_o=0, LEDs_o=0, err_o=0, sticky=0, wr_count=0, synchroniser flops=0. RAM contents are not reset.
- Decode:
  - RAM when address_i < 4*2**ADDR_W; word index = address_i[ADDR_W+1:2].
  - MMIO registers at MMIO_BASE+0 (LED), +4 (BTN), +8 (WCNT).
  - Everything else is unmapped.
- Read latency: 1 cycle. data_o is updated at the edge after the address is presented, every cycle, independent of rden_i.
- Read-during-write to the same RAM word returns the old data (read-first).
- Word read: full word. Byte read: lane zero-extended to 32 bits.
- RAM write (wren_i=1, RAM region):
  - Word mode writes all 4 lanes.
  - Byte mode writes only lane address_i[1:0], taking data_i[7:0]. Other lanes are preserved.
- LED: a write loads data_i[7:0]. Read returns {24'b0, LEDs_o}. Byte mode is treated as a word access for MMIO.
- BTN:
  - button_i passes through a 2-flop synchroniser giving btn_s.
  - A rising edge of btn_s sets sticky.
  - Read returns {30'b0, sticky, btn_s}.
  - A read with rden_i=1 clears sticky at that edge. If a set and a clear occur in the same cycle, set wins.
  - Writes are ignored.
- WCNT:
  - Increments by 1 on every accepted RAM write; wraps 32'hFFFF_FFFF to 0.
  - A write to WCNT clears it to 0. A RAM write cannot coincide with a WCNT write, since there is one address per cycle.
  - Read returns the pre-edge value.
- Unmapped access (wren_i or rden_i high):
  - err_o=1 for exactly the next cycle.
  - Writes are dropped; data_o=0.
- Reset mid-operation: RST overrides any write in the same cycle; no RAM write, no register update. The first post-reset cycle behaves normally.
- Data from the button reaches sticky 3 edges after the input rises (2 sync + edge detect).

Test Plan:
- Reset then read LED/BTN/WCNT: data_o=0, LEDs_o=0, err_o=0 for all.
- Word write 0xDEADBEEF to addr 0x10, read 0x10 next cycle: data_o=0xDEADBEEF one cycle after the address; WCNT reads 1.
- Byte write 0xAA to 0x12 (lane 2) over 0xDEADBEEF: word read gives 0xDEAABEEF; byte read at 0x12 gives 0x000000AA; read-during-write to 0x10 returns the old word.
- Write 0x5A to MMIO_BASE: LEDs_o=0x5A at next edge; write 0x1FF: LEDs_o=0xFF.
- Button pulse high 2 cycles: BTN reads 0x3, then 0x2 after release.
  - rden read clears it to 0x0.
  - Press and clear-read in the same cycle leaves sticky=1.
- Write to 0xFFFF_0000: err_o pulses one cycle, WCNT unchanged, RAM unchanged.
  - Preload WCNT via 2**32-1 writes (or forced) to confirm wrap to 0.
  - RST asserted together with wren_i: no RAM change.
